// File: rtl/window_mac3.sv
// window_mac3: three-tap sliding-window multiply-accumulate.
// Pops one entry per read from an upstream FIFO that presents three
// consecutive entries, multiplies unsigned activations by signed weights
// and emits one partial sum per window through a two-stage pipeline.
module window_mac3 #(
  parameter int DAT_WIDTH     = 8,
  parameter int NUM_RDATA     = 3,
  parameter int FF_ADDR_WIDTH = 3,
  parameter int PSUM_WIDTH    = 20,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           out_len,
  input  logic                           wgt_wr,
  input  logic [1:0]                     wgt_idx,
  input  logic [DAT_WIDTH-1:0]           wgt_data,
  input  logic [FF_ADDR_WIDTH-1:0]       ff_data_counter,
  input  logic                           ff_full,
  input  logic                           ff_empty,
  output logic                           ff_rd_req,
  input  logic [DAT_WIDTH*NUM_RDATA-1:0] ff_rd_data,
  output logic [PSUM_WIDTH-1:0]          psum,
  output logic                           psum_val,
  output logic                           busy,
  output logic                           done
);

  localparam int PROD_W = 2*DAT_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                  state;
  logic [LEN_WIDTH-1:0]        remaining;
  logic signed [DAT_WIDTH-1:0] wgt  [NUM_RDATA];
  logic signed [PROD_W-1:0]    prod [NUM_RDATA];
  logic                        rd_val1;
  logic                        val2;
  logic [PSUM_WIDTH-1:0]       sum_c;

  // Read when at least three entries are present; ff_full covers the
  // occupancy count wrapping to zero at a completely full FIFO.
  always_comb begin
    ff_rd_req = (state == RUN) && (remaining != '0) && !ff_empty &&
                (ff_full || (ff_data_counter >= FF_ADDR_WIDTH'(3)));
    busy      = (state != IDLE);
  end

  // Row control: load window count, count reads, drain, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_len != '0) begin
              state     <= RUN;
              remaining <= out_len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ff_rd_req) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rd_val1 && !val2) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight registers, writable only while idle; index 3 matches no tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RDATA; i++) wgt[i] <= '0;
    end else if (wgt_wr && (state == IDLE)) begin
      for (int unsigned i = 0; i < NUM_RDATA; i++)
        if (wgt_idx == 2'(i)) wgt[i] <= wgt_data;
    end
  end

  // Sum of the registered products, each sign-extended to the output width.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NUM_RDATA; i++)
      sum_c = sum_c + PSUM_WIDTH'(prod[i]);
  end

  // Datapath: own-read valid tracking, product stage, sum stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_val1  <= 1'b0;
      val2     <= 1'b0;
      psum_val <= 1'b0;
      psum     <= '0;
      for (int unsigned i = 0; i < NUM_RDATA; i++) prod[i] <= '0;
    end else begin
      rd_val1  <= ff_rd_req;
      val2     <= rd_val1;
      psum_val <= val2;
      if (rd_val1) begin
        for (int unsigned i = 0; i < NUM_RDATA; i++)
          prod[i] <= PROD_W'($signed({1'b0, ff_rd_data[i*DAT_WIDTH +: DAT_WIDTH]})) *
                     PROD_W'(wgt[i]);
      end
      if (val2) psum <= sum_c;
    end
  end

endmodule

// File: doc/window_mac3.md
WINDOW_MAC3 -- requirements
Module: window_mac3

Interface
REQ-001 Parameter DAT_WIDTH, default 8: width of one activation and one weight.
REQ-002 Parameter NUM_RDATA, default 3: window taps per FIFO read; fixed at 3.
REQ-003 Parameter FF_ADDR_WIDTH, default 3: width of the upstream FIFO occupancy count.
REQ-004 Parameter PSUM_WIDTH, default 20: width of the partial-sum output.
REQ-005 Parameter LEN_WIDTH, default 8: width of the window-count register.
REQ-006 Reset is rst, synchronous, active-high; the clock is clk.
REQ-007 The ports SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse that begins a row
- out_len  in  LEN_WIDTH  number of windows in the row; sampled on start
- wgt_wr  in  1  weight write strobe
- wgt_idx  in  2  weight tap index, 0..2
- wgt_data  in  DAT_WIDTH  signed weight value
- ff_data_counter  in  FF_ADDR_WIDTH  upstream FIFO occupancy
- ff_full  in  1  upstream FIFO full
- ff_empty  in  1  upstream FIFO empty
- ff_rd_req  out  1  pop-one / read-three request to the FIFO
- ff_rd_data  in  DAT_WIDTH*3  window data; tap0 in the LSBs, registered by the FIFO
- psum  out  PSUM_WIDTH  signed dot product
- psum_val  out  1  psum valid, one cycle per window
- busy  out  1  high in RUN and DRAIN
- done  out  1  single-cycle pulse at end of row

Function
REQ-008 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-009 IDLE transitions:
- start=1 with out_len>0 goes to RUN and loads remaining=out_len.
- start=1 with out_len=0 pulses done on the next cycle and stays in IDLE.
REQ-010 start SHALL be ignored while busy=1.
REQ-011 Weights SHALL be held in three signed registers.
- wgt_wr=1 in IDLE writes wgt_data to register wgt_idx.
- wgt_idx=3 and any write while busy SHALL be ignored.
REQ-012 In RUN, ff_rd_req=1 SHALL be driven combinationally when remaining>0, ff_empty=0, and (ff_full=1 or ff_data_counter>=3).
- The ff_full term covers occupancy-count wrap at a full FIFO.
REQ-013 Each cycle with ff_rd_req=1 SHALL decrement remaining by 1.
- The cycle that issues the read making remaining 0 moves the FSM to DRAIN.
REQ-014 The block SHALL derive data validity internally by registering its own issued read one cycle.
- ff_rd_data is sampled only in the cycle after a read was issued; zeros from the FIFO in other cycles are not treated as data.
REQ-015 Activations SHALL be unsigned and weights signed.
- Each product is (zero-extended activation) x (signed weight).
- The 3-product sum is sign-extended to PSUM_WIDTH; no saturation and no overflow at the defaults.
REQ-016 Pipeline:
- Stage 1 registers the three products in the cycle after data arrives.
- Stage 2 registers the sum and asserts psum_val.
- Latency is 3 cycles from a ff_rd_req cycle to its psum_val cycle.
- Throughput is one window per cycle.
REQ-017 psum SHALL hold its last value when psum_val=0.
REQ-018 DRAIN SHALL stay until no read is in flight in any pipeline stage, then pulse done for 1 cycle and return to IDLE.
- done coincides with the cycle after the last psum_val.
REQ-019 Windows SHALL be emitted in read order with no drop or duplication; stalls due to low occupancy insert bubbles only.

Reset
REQ-020 While rst=1, the block SHALL reset to IDLE with remaining=0, all weights=0, the pipeline valids cleared, and psum=0.
- ff_rd_req=0, psum_val=0, busy=0 and done=0.
REQ-021 rst asserted mid-row SHALL abort the row at the next edge.
- No further psum_val or done is produced.
- No ff_rd_req is issued in the cycle after rst deasserts.

Verification
REQ-022 Weights {1,2,3}, out_len=3, FIFO preloaded with 10,20,30,40,50 -> psum 140, 200, 260 on 3 consecutive cycles starting 3 cycles after the first read, then done.
REQ-023 Weights {-1,0,1}, activations 255,0,0 -> psum=-255, sign-extended to 20 bits (0xFFF01).
REQ-024 FIFO holds only 2 entries after start -> ff_rd_req stays 0; the third write enables a read, psum_val follows 3 cycles later.
REQ-025 FIFO full with counter wrapped to 0 -> ff_rd_req=1 is still issued; the window is correct.
REQ-026 start with out_len=0 -> single done pulse, no ff_rd_req, no psum_val.
REQ-027 rst asserted in RUN with 2 windows in flight -> no psum_val or done after reset, all outputs at reset values, weights cleared.
